// File: rtl/otter_fetch_unit_if.sv
// Bus bundle between the Otter fetch stage and the rest of the core:
// control-unit advance request, next-PC target buses, the instruction
// memory handshake and the fetch-stage results.
interface otter_fetch_unit_if;

    // control unit -> fetch
    logic        PC_WRITE;
    logic [2:0]  PC_SOURCE;

    // next-PC candidates from the execute stage / CSR file
    logic [31:0] JALR_TGT;
    logic [31:0] BRANCH_TGT;
    logic [31:0] JAL_TGT;
    logic [31:0] MTVEC;
    logic [31:0] MEPC;

    // instruction memory -> fetch
    logic [31:0] IMEM_DATA;
    logic        IMEM_VALID;

    // fetch -> instruction memory
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RD_EN;

    // fetch -> immediate generator / decoder / control unit
    logic [31:0] PC;
    logic [31:0] IR;
    logic        IR_VALID;
    logic        MISALIGN;
    logic        FETCH_ERR;

    // The fetch unit's own view of the bundle.
    modport master (
        input  PC_WRITE,
        input  PC_SOURCE,
        input  JALR_TGT,
        input  BRANCH_TGT,
        input  JAL_TGT,
        input  MTVEC,
        input  MEPC,
        input  IMEM_DATA,
        input  IMEM_VALID,
        output IMEM_ADDR,
        output IMEM_RD_EN,
        output PC,
        output IR,
        output IR_VALID,
        output MISALIGN,
        output FETCH_ERR
    );

    // The surrounding core / memory view of the bundle.
    modport slave (
        output PC_WRITE,
        output PC_SOURCE,
        output JALR_TGT,
        output BRANCH_TGT,
        output JAL_TGT,
        output MTVEC,
        output MEPC,
        output IMEM_DATA,
        output IMEM_VALID,
        input  IMEM_ADDR,
        input  IMEM_RD_EN,
        input  PC,
        input  IR,
        input  IR_VALID,
        input  MISALIGN,
        input  FETCH_ERR
    );

endinterface

// File: rtl/otter_fetch_unit.sv
// Otter instruction-fetch stage.
// Owns the PC, selects the next PC from the core's target buses, fetches the
// word at PC over a valid handshake with a bounded wait, and holds it in IR.
// Two states: FETCH (request outstanding) and READY (IR holds the word at PC).
module otter_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16,            // must be >= 2
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013  // addi x0,x0,0
) (
    input  logic CLK,
    input  logic RST,
    otter_fetch_unit_if.master bus
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_ir_valid;
    logic        r_misalign;
    logic        r_fetch_err;
    logic [CW-1:0] r_cnt;

    logic [CW-1:0] w_cnt_next;
    logic        w_ir_valid_next;
    logic        w_misalign_next;
    logic        w_pc_load;
    logic        w_ir_load;
    logic [31:0] w_ir_next;
    logic        w_err_set;

    // ------------------------------------------------------------------
    // Next-PC selection: one candidate per PC_SOURCE code, AND-OR muxed.
    // Codes 6 and 7 fall back to sequential execution.
    // ------------------------------------------------------------------
    logic [31:0] w_pc_plus4;
    logic [31:0] w_tgt      [8];
    logic [31:0] w_tgt_gated[8];
    logic [7:0]  w_sel_hit;
    logic [31:0] w_raw_tgt;
    logic [31:0] w_pc_aligned;
    logic        w_tgt_misaligned;

    // Sequential successor; wraps modulo 2^32 with no carry out.
    assign w_pc_plus4 = r_pc + 32'd4;

    assign w_tgt[0] = w_pc_plus4;
    assign w_tgt[1] = bus.JALR_TGT;
    assign w_tgt[2] = bus.BRANCH_TGT;
    assign w_tgt[3] = bus.JAL_TGT;
    assign w_tgt[4] = bus.MTVEC;
    assign w_tgt[5] = bus.MEPC;
    assign w_tgt[6] = w_pc_plus4;
    assign w_tgt[7] = w_pc_plus4;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sel
            assign w_sel_hit[gi]   = (bus.PC_SOURCE == 3'(gi));
            assign w_tgt_gated[gi] = w_tgt[gi] & {32{w_sel_hit[gi]}};
        end
    endgenerate

    // OR-reduce the gated candidates; exactly one is non-zero-gated.
    always_comb begin
        w_raw_tgt = '0;
        for (int k = 0; k < 8; k++) begin
            w_raw_tgt = w_raw_tgt | w_tgt_gated[k];
        end
    end

    // The PC is always word aligned; low bits of the raw target only flag.
    assign w_pc_aligned     = {w_raw_tgt[31:2], 2'b00};
    assign w_tgt_misaligned = |w_raw_tgt[1:0];

    // ------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and datapath controls.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_ir_valid_next = r_ir_valid;
        w_misalign_next = 1'b0;
        w_pc_load       = 1'b0;
        w_ir_load       = 1'b0;
        w_ir_next       = bus.IMEM_DATA;
        w_err_set       = 1'b0;

        unique case (r_state)
            S_FETCH: begin
                if (bus.IMEM_VALID) begin
                    // Valid data beats a coincident timeout.
                    w_ir_load       = 1'b1;
                    w_ir_next       = bus.IMEM_DATA;
                    w_ir_valid_next = 1'b1;
                    w_cnt_next      = '0;
                    w_state_next    = S_READY;
                end else if (r_cnt == CNT_LAST) begin
                    // Give up: present a NOP so the core keeps moving.
                    w_ir_load       = 1'b1;
                    w_ir_next       = NOP_WORD;
                    w_ir_valid_next = 1'b1;
                    w_err_set       = 1'b1;
                    w_cnt_next      = '0;
                    w_state_next    = S_READY;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_READY: begin
                if (bus.PC_WRITE) begin
                    w_pc_load       = 1'b1;
                    w_ir_valid_next = 1'b0;
                    w_misalign_next = w_tgt_misaligned;
                    w_state_next    = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // Datapath registers: PC, IR, flags and the fetch wait counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc        <= RESET_VEC;
            r_ir        <= NOP_WORD;
            r_ir_valid  <= 1'b0;
            r_misalign  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_ir_valid <= w_ir_valid_next;
            r_misalign <= w_misalign_next;
            if (w_pc_load) begin
                r_pc <= w_pc_aligned;
            end
            if (w_ir_load) begin
                r_ir <= w_ir_next;
            end
            if (w_err_set) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered state or direct decodes of it.
    // ------------------------------------------------------------------
    assign bus.IMEM_ADDR  = r_pc;
    assign bus.IMEM_RD_EN = (r_state == S_FETCH);
    assign bus.PC         = r_pc;
    assign bus.IR         = r_ir;
    assign bus.IR_VALID   = r_ir_valid;
    assign bus.MISALIGN   = r_misalign;
    assign bus.FETCH_ERR  = r_fetch_err;

    // The PC never moves while a fetch is outstanding.
    a_pc_stable_in_fetch : assert property (
        @(posedge CLK) (!RST && r_state == S_FETCH) |=> (r_pc == $past(r_pc))
    );

    // MISALIGN is a single-cycle pulse.
    a_misalign_pulse : assert property (
        @(posedge CLK) r_misalign |=> !r_misalign
    );

endmodule
